// File: rtl/teletext_video_timing.sv
// Raster timing generator for the teletext display path: pixel strobe, syncs,
// active-video flags, 40x25 character-cell grid and flash phase.
module teletext_video_timing #(
  parameter int unsigned CLK_DIV      = 1,
  parameter int unsigned H_TOTAL      = 1056,
  parameter int unsigned H_ACTIVE     = 800,
  parameter int unsigned H_SYNC_START = 840,
  parameter int unsigned H_SYNC_LEN   = 128,
  parameter int unsigned V_TOTAL      = 628,
  parameter int unsigned V_ACTIVE     = 600,
  parameter int unsigned V_SYNC_START = 601,
  parameter int unsigned V_SYNC_LEN   = 4,
  parameter int unsigned SYNC_POL     = 1,
  parameter int unsigned X_OFFSET     = 160,
  parameter int unsigned Y_OFFSET     = 50,
  parameter int unsigned FLASH_ON     = 48,
  parameter int unsigned FLASH_OFF    = 16
) (
  input  logic        master_clock,
  input  logic        reset,
  output logic        pixel_en,
  output logic [10:0] h_pos,
  output logic [9:0]  v_pos,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic        tt_active,
  output logic [5:0]  char_col,
  output logic [4:0]  char_row,
  output logic [4:0]  char_line,
  output logic [3:0]  char_px,
  output logic        char_start,
  output logic        frame_start,
  output logic        flash_phase
);
  localparam int unsigned HW          = 11;
  localparam int unsigned VW          = 10;
  localparam int unsigned COL_W       = 6;
  localparam int unsigned ROW_W       = 5;
  localparam int unsigned LINE_W      = 5;
  localparam int unsigned PX_W        = 4;
  localparam int unsigned TT_W        = 480;
  localparam int unsigned TT_H        = 500;
  localparam int unsigned CELL_W      = 12;
  localparam int unsigned CELL_H      = 20;
  localparam int unsigned DIV_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned FLASH_TOTAL = FLASH_ON + FLASH_OFF;
  localparam int unsigned FC_W        = $clog2(FLASH_TOTAL + 1);
  localparam logic        SYNC_IDLE   = (SYNC_POL == 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0]  div_cnt, div_next;
  logic              tick, started, line_end;
  logic [HW-1:0]     h_next;
  logic [VW-1:0]     v_next;
  logic [PX_W-1:0]   px_cnt, px_next;
  logic [COL_W-1:0]  col_cnt, col_next;
  logic [LINE_W-1:0] line_cnt, line_next;
  logic [ROW_W-1:0]  row_cnt, row_next;
  logic [FC_W-1:0]   flash_cnt, flash_next;
  logic              h_in, v_in, tt_next, fs_next, hs_act, vs_act;

  // Next raster position; every registered flag decodes this same value.
  always_comb begin
    tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    div_next = tick ? '0 : div_cnt + DIV_W'(1);
    line_end = pixel_en && (h_pos == HW'(H_TOTAL - 1));
    h_next   = h_pos;
    v_next   = v_pos;
    if (pixel_en) h_next = line_end ? '0 : h_pos + HW'(1);
    if (line_end) v_next = (v_pos == VW'(V_TOTAL - 1)) ? '0 : v_pos + VW'(1);

    h_in = (h_next >= HW'(X_OFFSET)) && (h_next < HW'(X_OFFSET + TT_W));
    v_in = (v_next >= VW'(Y_OFFSET)) && (v_next < VW'(Y_OFFSET + TT_H));

    // Cell counters restart at the area's left/top edge and freeze outside it.
    px_next   = px_cnt;
    col_next  = col_cnt;
    line_next = line_cnt;
    row_next  = row_cnt;
    if (pixel_en) begin
      if (h_next == HW'(X_OFFSET)) begin
        px_next  = '0;
        col_next = '0;
      end else if (h_in) begin
        if (px_cnt == PX_W'(CELL_W - 1)) begin
          px_next  = '0;
          col_next = col_cnt + COL_W'(1);
        end else begin
          px_next = px_cnt + PX_W'(1);
        end
      end
    end
    if (line_end) begin
      if (v_next == VW'(Y_OFFSET)) begin
        line_next = '0;
        row_next  = '0;
      end else if (v_in) begin
        if (line_cnt == LINE_W'(CELL_H - 1)) begin
          line_next = '0;
          row_next  = row_cnt + ROW_W'(1);
        end else begin
          line_next = line_cnt + LINE_W'(1);
        end
      end
    end

    tt_next = h_in && v_in;
    hs_act  = (h_next >= HW'(H_SYNC_START)) && (h_next < HW'(H_SYNC_START + H_SYNC_LEN));
    vs_act  = (v_next >= VW'(V_SYNC_START)) && (v_next < VW'(V_SYNC_START + V_SYNC_LEN));
    // The very first pixel after reset is frame 0, not a frame boundary.
    fs_next = tick && started && (h_next == '0) && (v_next == '0);
    flash_next = flash_cnt;
    if (fs_next) flash_next = (flash_cnt == FC_W'(FLASH_TOTAL - 1)) ? '0 : flash_cnt + FC_W'(1);
  end

  always_ff @(posedge master_clock or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      started      <= 1'b0;
      px_cnt       <= '0;
      col_cnt      <= '0;
      line_cnt     <= '0;
      row_cnt      <= '0;
      flash_cnt    <= '0;
      pixel_en     <= 1'b0;
      h_pos        <= '0;
      v_pos        <= '0;
      hsync        <= SYNC_IDLE;
      vsync        <= SYNC_IDLE;
      video_active <= 1'b0;
      tt_active    <= 1'b0;
      char_col     <= '0;
      char_row     <= '0;
      char_line    <= '0;
      char_px      <= '0;
      char_start   <= 1'b0;
      frame_start  <= 1'b0;
      flash_phase  <= 1'b1;
    end else begin
      div_cnt      <= div_next;
      started      <= started | tick;
      px_cnt       <= px_next;
      col_cnt      <= col_next;
      line_cnt     <= line_next;
      row_cnt      <= row_next;
      flash_cnt    <= flash_next;
      pixel_en     <= tick;
      h_pos        <= h_next;
      v_pos        <= v_next;
      hsync        <= (SYNC_POL != 0) ? hs_act : !hs_act;
      vsync        <= (SYNC_POL != 0) ? vs_act : !vs_act;
      video_active <= (h_next < HW'(H_ACTIVE)) && (v_next < VW'(V_ACTIVE));
      tt_active    <= tt_next;
      char_col     <= tt_next ? col_next : '0;
      char_row     <= tt_next ? row_next : '0;
      char_line    <= tt_next ? line_next : '0;
      char_px      <= tt_next ? px_next : '0;
      char_start   <= tt_next && (px_next == '0);
      frame_start  <= fs_next;
      flash_phase  <= (flash_next < FC_W'(FLASH_ON));
    end
  end
endmodule

// File: doc/teletext_video_timing.md
Name: teletext_video_timing

Overview:
- Consumes the FPGA system clock `master_clock` and produces every raster-timing signal the teletext display path needs.
- Outputs: pixel enable, h/v sync, active-video flags, a teletext character-cell grid (40 columns x 25 rows, 12x20-pixel cells) and the flash phase.
- Sits directly downstream of the clock block and drives the page-memory reader and character ROM/serialiser.

Parameters:
- CLK_DIV, 1, master_clock cycles per pixel (1..16)
- H_TOTAL, 1056, pixels per line
- H_ACTIVE, 800, visible pixels per line
- H_SYNC_START, 840, first pixel of hsync
- H_SYNC_LEN, 128, hsync width in pixels
- V_TOTAL, 628, lines per frame
- V_ACTIVE, 600, visible lines
- V_SYNC_START, 601, first line of vsync
- V_SYNC_LEN, 4, vsync width in lines
- SYNC_POL, 1, 1 = syncs active-high, 0 = active-low
- X_OFFSET, 160, first pixel of the teletext area
- Y_OFFSET, 50, first line of the teletext area
- FLASH_ON, 48, frames with flash_phase=1
- FLASH_OFF, 16, frames with flash_phase=0

Ports:
- master_clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pixel_en  out  1  one-cycle strobe per pixel
- h_pos  out  11  pixel counter 0..H_TOTAL-1
- v_pos  out  10  line counter 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- video_active  out  1  h_pos<H_ACTIVE and v_pos<V_ACTIVE
- tt_active  out  1  current pixel inside the 480x500 teletext area
- char_col  out  6  character column 0..39
- char_row  out  5  character row 0..24
- char_line  out  5  scan line within the cell, 0..19
- char_px  out  4  pixel within the cell, 0..11
- char_start  out  1  high on char_px==0 inside the teletext area
- frame_start  out  1  one pixel_en-wide pulse at h_pos=0, v_pos=0
- flash_phase  out  1  teletext flash state

Behaviour:
- Reset (async, active-high): all counters 0, pixel_en=0, h_pos=0, v_pos=0, syncs at their inactive level, all flags 0, char_* = 0, flash_phase=1, flash frame counter 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1; pixel_en=1 in the cycle where div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pixel_en is constantly 1 from the first edge after reset release.
- Counters advance only on pixel_en:
  - h_pos wraps H_TOTAL-1 -> 0, and v_pos increments on that wrap.
  - v_pos wraps V_TOTAL-1 -> 0.
- All other outputs are registered decodes of the same (h_pos, v_pos) value presented in the same cycle. There is no skew between h_pos/v_pos and any flag.
- hsync active for H_SYNC_START <= h_pos < H_SYNC_START+H_SYNC_LEN; vsync likewise on v_pos.
- tt_active when X_OFFSET <= h_pos < X_OFFSET+480 and Y_OFFSET <= v_pos < Y_OFFSET+500.
- Cell counters:
  - Implemented as incrementing counters, not dividers.
  - char_px and char_col reset to 0 at h_pos==X_OFFSET; char_px wraps 11->0 with char_col+1.
  - char_line and char_row reset at v_pos==Y_OFFSET; char_line wraps 19->0 with char_row+1 at each line end.
  - Outside the teletext area the char_* values hold at 0.
- char_start = tt_active and char_px==0. frame_start is high while h_pos=0, v_pos=0 and pixel_en=1.
- Flash:
  - Frame counter increments at each frame_start.
  - flash_phase=1 for FLASH_ON frames, then 0 for FLASH_OFF frames, repeating (64-frame period by default).
- Reset asserted mid-frame: every output returns to its reset value asynchronously. After release, counting restarts from h_pos=0, v_pos=0 with no partial-frame pulses.

Test Plan:
- Release reset, CLK_DIV=1 -> pixel_en=1 every cycle; h_pos runs 0..1055, then 0 with v_pos=1; 663168 cycles per frame.
- CLK_DIV=4 -> pixel_en high 1 cycle in 4; h_pos steps once per 4 cycles; a line takes 4224 cycles.
- Line scan -> hsync high exactly at h_pos 840..967; vsync high on v_pos 601..604; video_active low from h_pos 800; SYNC_POL=0 inverts both syncs.
- Teletext grid:
  - At v_pos=50, h_pos=160: char_col=0, char_px=0, char_start=1.
  - At h_pos=172: char_col=1.
  - At h_pos=639: char_col=39, char_px=11.
  - At h_pos=640: tt_active=0.
  - At v_pos=549: char_row=24, char_line=19.
- Flash over 130 frames -> flash_phase=1 for frames 0..47, 0 for 48..63, 1 again at 64.
- Assert reset at h_pos=500, v_pos=300 -> all outputs at reset values within the same cycle; after release, first frame_start occurs after exactly H_TOTAL*V_TOTAL pixels.
